// File: rtl/rf_dmem_storage.sv
// rf_dmem_storage -- register file plus data memory for the simplified 64-bit datapath.
//
// Register file: 32 x WORDSIZE, two combinational read ports (A/B), one synchronous
// write port. Register 0 always reads zero and ignores writes.
// Data memory: DM_DEPTH x WORDSIZE, synchronous write and registered read sharing one
// address. A read and a write in the same cycle return the old word (read-before-write).
// Addresses at or beyond DM_DEPTH ignore writes and read back zero.
//
// Optional build macro:
//   RF_BYPASS_EN  forward rf_wdata to a read port whose address matches a pending
//                 (non-zero) RF write in the same cycle.
//
// Ports:
//   clk                     clock, all state updates on the rising edge
//   reset                   synchronous active-high reset; clears RF, DM and dm_rdata
//   rf_we/rf_waddr/rf_wdata RF write port
//   rf_addr_a/rf_addr_b     RF read addresses
//   rf_data_a/rf_data_b     RF read data (combinational)
//   dm_addr                 DM address shared by read and write
//   dm_wdata/dm_we          DM write data and enable
//   dm_read                 DM read strobe; dm_rdata holds when low
//   dm_rdata                DM read data (registered, one-cycle latency)

module rf_dmem_storage #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DM_DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rf_we,
  input  logic [ADDR_W-1:0]   rf_waddr,
  input  logic [WORDSIZE-1:0] rf_wdata,
  input  logic [ADDR_W-1:0]   rf_addr_a,
  input  logic [ADDR_W-1:0]   rf_addr_b,
  output logic [WORDSIZE-1:0] rf_data_a,
  output logic [WORDSIZE-1:0] rf_data_b,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [WORDSIZE-1:0] dm_wdata,
  input  logic                dm_we,
  input  logic                dm_read,
  output logic [WORDSIZE-1:0] dm_rdata
);

  localparam int unsigned RfDepth = 32;
  localparam int unsigned DmIdxW  = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  // One extra bit so DM_DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DmLimit = (ADDR_W + 1)'(DM_DEPTH);

  logic [WORDSIZE-1:0] rf_q  [RfDepth];
  logic [WORDSIZE-1:0] mem_q [DM_DEPTH];
  logic [WORDSIZE-1:0] dm_rdata_q;

  logic              dm_in_range;
  logic [DmIdxW-1:0] dm_idx;
  logic              rf_wr_valid;

  assign dm_in_range = ({1'b0, dm_addr} < DmLimit);
  assign dm_idx      = dm_addr[DmIdxW-1:0];
  assign rf_wr_valid = rf_we && (rf_waddr != '0);

  // Read ports. Register 0 is forced to zero here rather than relying on its storage.
  always_comb begin
    rf_data_a = '0;
    rf_data_b = '0;
    if (rf_addr_a != '0) begin
      rf_data_a = rf_q[rf_addr_a];
    end
    if (rf_addr_b != '0) begin
      rf_data_b = rf_q[rf_addr_b];
    end
`ifdef RF_BYPASS_EN
    if (rf_wr_valid && (rf_waddr == rf_addr_a)) begin
      rf_data_a = rf_wdata;
    end
    if (rf_wr_valid && (rf_waddr == rf_addr_b)) begin
      rf_data_b = rf_wdata;
    end
`endif
  end

  // Reset wins over every write and read issued in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RfDepth; i++) begin
        rf_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dm_rdata_q <= '0;
    end else begin
      if (rf_wr_valid) begin
        rf_q[rf_waddr] <= rf_wdata;
      end
      if (dm_we && dm_in_range) begin
        mem_q[dm_idx] <= dm_wdata;
      end
      // Non-blocking read samples the pre-write word: read-before-write.
      if (dm_read) begin
        dm_rdata_q <= dm_in_range ? mem_q[dm_idx] : '0;
      end
    end
  end

  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_rf_dmem_storage.sv
// Directed self-checking bench for rf_dmem_storage (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next one.

module tb_rf_dmem_storage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic [63:0] rf_data_a;
  logic [63:0] rf_data_b;
  logic [4:0]  dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_we;
  logic        dm_read;
  logic [63:0] dm_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_dmem_storage #(
    .WORDSIZE (64),
    .ADDR_W   (5),
    .DM_DEPTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_addr_a (rf_addr_a),
    .rf_addr_b (rf_addr_b),
    .rf_data_a (rf_data_a),
    .rf_data_b (rf_data_b),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_we     (dm_we),
    .dm_read   (dm_read),
    .dm_rdata  (dm_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    dm_read  = 1'b0;
    dm_wdata = '0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [63:0] d);
    rf_we    = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    tick();
    rf_we    = 1'b0;
  endtask

  task automatic dm_write(input logic [4:0] a, input logic [63:0] d);
    dm_we    = 1'b1;
    dm_addr  = a;
    dm_wdata = d;
    tick();
    dm_we    = 1'b0;
  endtask

  task automatic dm_load(input logic [4:0] a);
    dm_read = 1'b1;
    dm_addr = a;
    tick();
    dm_read = 1'b0;
  endtask

  logic [63:0] exp_byp;

  initial begin
    idle();
    rf_addr_a = '0;
    rf_addr_b = '0;
    dm_addr   = '0;

    // 1. Reset clears everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_addr_a = 5'(i);
      rf_addr_b = 5'(31 - i);
      #1;
      check_eq($sformatf("rst_rf_a[%0d]", i), rf_data_a, 64'h0);
      check_eq($sformatf("rst_rf_b[%0d]", 31 - i), rf_data_b, 64'h0);
    end
    for (int i = 0; i < 32; i++) begin
      dm_load(5'(i));
      check_eq($sformatf("rst_dm[%0d]", i), dm_rdata, 64'h0);
    end

    // 2. RF write, dual-port read of the same address, x0 stays zero.
    rf_write(5'd5, 64'hDEAD_BEEF_0000_0001);
    rf_addr_a = 5'd5;
    rf_addr_b = 5'd5;
    #1;
    check_eq("rf5_a", rf_data_a, 64'hDEAD_BEEF_0000_0001);
    check_eq("rf5_b", rf_data_b, 64'hDEAD_BEEF_0000_0001);
    rf_write(5'd6, 64'h6666);
    rf_addr_b = 5'd6;
    #1;
    check_eq("rf5_a_after_rf6", rf_data_a, 64'hDEAD_BEEF_0000_0001);
    check_eq("rf6_b", rf_data_b, 64'h6666);
    rf_write(5'd0, 64'h1);
    rf_addr_a = 5'd0;
    #1;
    check_eq("rf0_zero", rf_data_a, 64'h0);

    // 3. DM store then registered load; hold while dm_read is low.
    dm_write(5'd3, 64'h0123_4567_89AB_CDEF);
    dm_write(5'd4, 64'h4444);
    dm_read = 1'b1;
    dm_addr = 5'd3;
    #1;
    check_eq("dm_pre_edge", dm_rdata, 64'h0);
    tick();
    dm_read = 1'b0;
    check_eq("dm3_load", dm_rdata, 64'h0123_4567_89AB_CDEF);
    dm_addr = 5'd4;
    tick();
    tick();
    check_eq("dm_hold", dm_rdata, 64'h0123_4567_89AB_CDEF);
    dm_load(5'd4);
    check_eq("dm4_load", dm_rdata, 64'h4444);

    // 4. Read-before-write on the same address.
    dm_write(5'd7, 64'hA);
    dm_we    = 1'b1;
    dm_read  = 1'b1;
    dm_addr  = 5'd7;
    dm_wdata = 64'hB;
    tick();
    dm_we    = 1'b0;
    dm_read  = 1'b0;
    check_eq("dm_rbw_old", dm_rdata, 64'hA);
    dm_load(5'd7);
    check_eq("dm_rbw_new", dm_rdata, 64'hB);

    // 5. Same-cycle write/read of the RF (bypass depends on build).
    rf_write(5'd9, 64'h11);
    rf_addr_a = 5'd9;
    rf_addr_b = 5'd5;
    rf_we     = 1'b1;
    rf_waddr  = 5'd9;
    rf_wdata  = 64'h55;
`ifdef RF_BYPASS_EN
    exp_byp = 64'h55;
`else
    exp_byp = 64'h11;
`endif
    #1;
    check_eq("rf9_same_cycle", rf_data_a, exp_byp);
    check_eq("rf5_unaffected", rf_data_b, 64'hDEAD_BEEF_0000_0001);
    tick();
    rf_we = 1'b0;
    check_eq("rf9_after_edge", rf_data_a, 64'h55);
    // Write to x0 never forwards.
    rf_we     = 1'b1;
    rf_waddr  = 5'd0;
    rf_wdata  = 64'h99;
    rf_addr_a = 5'd0;
    #1;
    check_eq("rf0_no_bypass", rf_data_a, 64'h0);
    tick();
    rf_we = 1'b0;

    // 6. Reset beats a concurrent RF and DM write.
    rf_write(5'd2, 64'hFF);
    rf_addr_a = 5'd2;
    #1;
    check_eq("rf2_loaded", rf_data_a, 64'hFF);
    reset    = 1'b1;
    rf_we    = 1'b1;
    rf_waddr = 5'd2;
    rf_wdata = 64'h77;
    dm_we    = 1'b1;
    dm_read  = 1'b1;
    dm_addr  = 5'd3;
    dm_wdata = 64'h5A5A;
    tick();
    idle();
    rf_addr_b = 5'd9;
    #1;
    check_eq("rf2_reset", rf_data_a, 64'h0);
    check_eq("rf9_reset", rf_data_b, 64'h0);
    check_eq("dm_rdata_reset", dm_rdata, 64'h0);
    dm_load(5'd3);
    check_eq("dm3_reset", dm_rdata, 64'h0);
    dm_load(5'd7);
    check_eq("dm7_reset", dm_rdata, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
